mem_stage_hs: RTL

- Parametrised memory-access pipeline stage between EX and WB in the five-stage core.
- Replaces the fixed stall-vector pipeline register with a valid/ready handshake.
- Waits for variable-latency data SRAM read responses and performs load byte/halfword/word extraction with sign or zero extension.
- Drives a forwarding bus to ID that includes a load-pending flag, so ID can stall on load-use hazards.

---
 rtl/mem_stage_hs.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_hs.sv
// Memory-access pipeline stage (EX -> WB) with valid/ready handshake, load extraction and ID forwarding.
// Optional misaligned-load detection enabled by defining MEM_MISALIGN_CHK_EN (adds out_misalign).
module mem_stage_hs #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5,
    parameter int LANE_W = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_mem_ren,
    input  logic [2:0]        in_ld_op,
    input  logic [LANE_W-1:0] in_addr_lo,
    input  logic              in_rf_we,
    input  logic [RF_AW-1:0]  in_rf_waddr,
    input  logic [DATA_W-1:0] in_ex_result,
    input  logic              dsram_rvalid,
    input  logic [DATA_W-1:0] dsram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_rf_we,
    output logic [RF_AW-1:0]  out_rf_waddr,
    output logic [DATA_W-1:0] out_rf_wdata,
    output logic              fwd_we,
    output logic [RF_AW-1:0]  fwd_waddr,
    output logic [DATA_W-1:0] fwd_wdata,
    output logic              fwd_load_pending
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic              out_misalign
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [LANE_W-1:0] HW_MASK = ~LANE_W'(1);
    localparam logic [LANE_W-1:0] W_MASK  = ~LANE_W'(3);

    logic [1:0]        state;
    logic              drop_pending;
    logic [PC_W-1:0]   pc_q;
    logic              rf_we_q;
    logic [RF_AW-1:0]  waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        ld_op_q;
    logic [LANE_W-1:0] addr_lo_q;

    logic              accept;
    logic              misalign_in;
    logic [LANE_W+2:0] sh_b;
    logic [LANE_W+2:0] sh_h;
    logic [LANE_W+2:0] sh_w;
    logic [7:0]        rd_b;
    logic [15:0]       rd_h;
    logic [31:0]       rd_w;
    logic [DATA_W-1:0] ld_data;

    assign in_ready = !drop_pending &&
                      ((state == ST_EMPTY) || ((state == ST_HOLD) && out_ready));
    assign accept   = in_valid && in_ready && !flush;

    // Lane offsets: halfword/word lanes are the byte address with low bits cleared.
    assign sh_b = {addr_lo_q, 3'b000};
    assign sh_h = {addr_lo_q & HW_MASK, 3'b000};
    assign sh_w = {addr_lo_q & W_MASK, 3'b000};
    assign rd_b = 8'(dsram_rdata >> sh_b);
    assign rd_h = 16'(dsram_rdata >> sh_h);
    assign rd_w = 32'(dsram_rdata >> sh_w);

    always_comb begin
        ld_data = dsram_rdata;
        case (ld_op_q)
            3'd1: begin ld_data = {DATA_W{rd_b[7]}};  ld_data[7:0]  = rd_b; end
            3'd2: begin ld_data = '0;                 ld_data[7:0]  = rd_b; end
            3'd3: begin ld_data = {DATA_W{rd_h[15]}}; ld_data[15:0] = rd_h; end
            3'd4: begin ld_data = '0;                 ld_data[15:0] = rd_h; end
            3'd5: begin ld_data = {DATA_W{rd_w[31]}}; ld_data[31:0] = rd_w; end
            3'd6: begin ld_data = '0;                 ld_data[31:0] = rd_w; end
            default: ld_data = dsram_rdata;
        endcase
    end

`ifdef MEM_MISALIGN_CHK_EN
    logic misalign_q;

    always_comb begin
        misalign_in = 1'b0;
        if (in_mem_ren) begin
            case (in_ld_op)
                3'd1, 3'd2: misalign_in = 1'b0;
                3'd3, 3'd4: misalign_in = in_addr_lo[0];
                3'd5, 3'd6: misalign_in = |in_addr_lo[1:0];
                default:    misalign_in = |in_addr_lo;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (accept)
            misalign_q <= misalign_in;
    end

    assign out_misalign = (state == ST_HOLD) && misalign_q;
`else
    assign misalign_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_EMPTY;
            drop_pending <= 1'b0;
            pc_q         <= '0;
            rf_we_q      <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            ld_op_q      <= '0;
            addr_lo_q    <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
            // A response still owed to a flushed load must not land on a later one.
            if (drop_pending && dsram_rvalid)
                drop_pending <= 1'b0;
            else if ((state == ST_WAIT) && !dsram_rvalid)
                drop_pending <= 1'b1;
        end else begin
            if (drop_pending && dsram_rvalid)
                drop_pending <= 1'b0;
            if (accept) begin
                state     <= (in_mem_ren && !misalign_in) ? ST_WAIT : ST_HOLD;
                pc_q      <= in_pc;
                rf_we_q   <= in_rf_we && !misalign_in;
                waddr_q   <= in_rf_waddr;
                wdata_q   <= misalign_in ? '0 : in_ex_result;
                ld_op_q   <= in_ld_op;
                addr_lo_q <= in_addr_lo;
            end else if ((state == ST_HOLD) && out_ready) begin
                state <= ST_EMPTY;
            end else if ((state == ST_WAIT) && dsram_rvalid) begin
                state   <= ST_HOLD;
                wdata_q <= ld_data;
            end
        end
    end

    assign out_valid        = (state == ST_HOLD);
    assign out_pc           = pc_q;
    assign out_rf_we        = rf_we_q;
    assign out_rf_waddr     = waddr_q;
    assign out_rf_wdata     = (state == ST_HOLD) ? wdata_q : '0;
    assign fwd_we           = rf_we_q && ((state == ST_HOLD) || (state == ST_WAIT));
    assign fwd_waddr        = waddr_q;
    assign fwd_wdata        = out_rf_wdata;
    assign fwd_load_pending = (state == ST_WAIT);

endmodule
